alu_acc_unit: RTL and testbench

//  Arithmetic datapath stage driven directly by the microprogrammed control word from the CU.

---
 rtl/alu_acc_unit.sv | 192 +++++++++++++++++++
 tb/tb_alu_acc_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_acc_unit.sv
// Accumulator datapath stage: executes one CU micro-operation per clock on ACC/BR/MR.
// Signed multiply runs as an iterative shift-add over W steps, followed by one writeback cycle.
module alu_acc_unit #(
  parameter int W     = 16,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  ctrl,
  input  logic [W-1:0] mbr_in,
  output logic [W-1:0] data_out,
  output logic [7:0]   flags,
  output logic         busy
);

  localparam int W1 = W + 1;
  localparam int W2 = 2 * W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t            state, state_d;
  logic [W-1:0]      acc, acc_d;
  logic [W-1:0]      br, br_d;
  logic [W-1:0]      mr, mr_d;
  logic              flag_n, flag_n_d;
  logic              flag_z, flag_z_d;
  logic              flag_c, flag_c_d;
  logic              flag_v, flag_v_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [W2-1:0]     mcand, mcand_d;
  logic [W-1:0]      mplier, mplier_d;
  logic [W2-1:0]     prod, prod_d;
  logic              mul_neg, mul_neg_d;
  logic              acc_wr;

  logic [W:0]        add_sum;
  logic [W:0]        sub_sum;
  logic [W-1:0]      acc_mag;
  logic [W-1:0]      br_mag;
  logic [W2-1:0]     mul_result;
  logic              unused_ctrl;

  assign add_sum    = {1'b0, acc} + {1'b0, br};
  // Subtract as ACC + ~BR + 1 so the carry out is the no-borrow flag.
  assign sub_sum    = {1'b0, acc} + {1'b0, ~br} + W1'(1);
  assign acc_mag    = acc[W-1] ? (~acc) + W'(1) : acc;
  assign br_mag     = br[W-1]  ? (~br)  + W'(1) : br;
  assign mul_result = mul_neg  ? (~prod) + W2'(1) : prod;

  assign busy        = (state != S_IDLE);
  assign flags       = {3'b000, busy, flag_v, flag_c, flag_z, flag_n};
  assign unused_ctrl = ^{ctrl[20:17], ctrl[14:12], ctrl[9:7], ctrl[5:0]};

  always_comb begin
    data_out = '0;
    if (ctrl[11] || ctrl[16]) data_out = acc;
    else if (ctrl[15])        data_out = mr;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state;
    acc_d     = acc;
    br_d      = br;
    mr_d      = mr;
    flag_n_d  = flag_n;
    flag_z_d  = flag_z;
    flag_c_d  = flag_c;
    flag_v_d  = flag_v;
    cnt_d     = cnt;
    mcand_d   = mcand;
    mplier_d  = mplier;
    prod_d    = prod;
    mul_neg_d = mul_neg;
    acc_wr    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (ctrl[6]) br_d = mbr_in;
        // Op bits always see the BR value from before this edge.
        if (|ctrl[31:22]) begin
          acc_wr = 1'b1;
          if (ctrl[22]) begin
            acc_d    = add_sum[W-1:0];
            flag_c_d = add_sum[W];
            flag_v_d = (acc[W-1] == br[W-1]) && (add_sum[W-1] != acc[W-1]);
          end else if (ctrl[23]) begin
            acc_d    = sub_sum[W-1:0];
            flag_c_d = sub_sum[W];
            flag_v_d = (acc[W-1] != br[W-1]) && (sub_sum[W-1] != acc[W-1]);
          end else if (ctrl[24]) begin
            acc_d = acc & br;
          end else if (ctrl[25]) begin
            acc_d = acc | br;
          end else if (ctrl[26]) begin
            acc_d = ~br;
          end else if (ctrl[27]) begin
            acc_d    = {acc[W-2:0], 1'b0};
            flag_c_d = acc[W-1];
          end else if (ctrl[28]) begin
            acc_d    = {1'b0, acc[W-1:1]};
            flag_c_d = acc[0];
          end else if (ctrl[29]) begin
            acc_wr    = 1'b0;
            state_d   = S_MUL;
            mcand_d   = {{W{1'b0}}, acc_mag};
            mplier_d  = br_mag;
            mul_neg_d = acc[W-1] ^ br[W-1];
            prod_d    = '0;
            cnt_d     = '0;
          end else if (ctrl[30]) begin
            acc_d    = {acc[W-2:0], 1'b0};
            flag_c_d = acc[W-1];
            flag_v_d = acc[W-1] ^ acc[W-2];
          end else begin
            acc_d    = {acc[W-1], acc[W-1:1]};
            flag_c_d = acc[0];
          end
        end else if (ctrl[10]) begin
          acc_wr = 1'b1;
          acc_d  = mbr_in;
        end else if (ctrl[21]) begin
          acc_wr = 1'b1;
          acc_d  = '0;
        end
      end

      S_MUL: begin
        if (mplier[0]) prod_d = prod + mcand;
        mcand_d  = mcand << 1;
        mplier_d = mplier >> 1;
        cnt_d    = cnt + CNT_W'(1);
        if (cnt == CNT_W'(W - 1)) state_d = S_DONE;
      end

      S_DONE: begin
        {mr_d, acc_d} = mul_result;
        flag_n_d      = mul_result[W2-1];
        flag_z_d      = (mul_result == '0);
        flag_c_d      = 1'b0;
        flag_v_d      = 1'b0;
        cnt_d         = '0;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (acc_wr) begin
      flag_n_d = acc_d[W-1];
      flag_z_d = (acc_d == '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      acc     <= '0;
      br      <= '0;
      mr      <= '0;
      flag_n  <= 1'b0;
      flag_z  <= 1'b1;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      mul_neg <= 1'b0;
    end else begin
      state   <= state_d;
      acc     <= acc_d;
      br      <= br_d;
      mr      <= mr_d;
      flag_n  <= flag_n_d;
      flag_z  <= flag_z_d;
      flag_c  <= flag_c_d;
      flag_v  <= flag_v_d;
      cnt     <= cnt_d;
      mcand   <= mcand_d;
      mplier  <= mplier_d;
      prod    <= prod_d;
      mul_neg <= mul_neg_d;
    end
  end

endmodule

// File: tb/tb_alu_acc_unit.sv
// Directed bench for alu_acc_unit (W=16): load/arith/logic/shift ops, multiply latency
// and boundaries, asynchronous reset including mid-multiply abort.
module tb_alu_acc_unit;

  localparam int W = 16;

  localparam logic [31:0] B_MBR2BR  = 32'h1 << 6;
  localparam logic [31:0] B_MBR2ACC = 32'h1 << 10;
  localparam logic [31:0] B_ACC2MBR = 32'h1 << 11;
  localparam logic [31:0] B_MR2MBR  = 32'h1 << 15;
  localparam logic [31:0] B_ALU2MBR = 32'h1 << 16;
  localparam logic [31:0] B_CLR     = 32'h1 << 21;
  localparam logic [31:0] B_ADD     = 32'h1 << 22;
  localparam logic [31:0] B_SUB     = 32'h1 << 23;
  localparam logic [31:0] B_NOT     = 32'h1 << 26;
  localparam logic [31:0] B_LSL     = 32'h1 << 27;
  localparam logic [31:0] B_LSR     = 32'h1 << 28;
  localparam logic [31:0] B_MPY     = 32'h1 << 29;
  localparam logic [31:0] B_ASL     = 32'h1 << 30;
  localparam logic [31:0] B_ASR     = 32'h1 << 31;

  logic         clk;
  logic         rst;
  logic [31:0]  ctrl;
  logic [W-1:0] mbr_in;
  logic [W-1:0] data_out;
  logic [7:0]   flags;
  logic         busy;

  int checks;
  int errors;

  alu_acc_unit #(.W(W), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .ctrl     (ctrl),
    .mbr_in   (mbr_in),
    .data_out (data_out),
    .flags    (flags),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given control word; returns 1 time unit after the edge.
  task automatic cyc(input logic [31:0] c, input logic [W-1:0] m);
    ctrl   = c;
    mbr_in = m;
    @(posedge clk);
    #1;
    ctrl = '0;
  endtask

  task automatic read_sel(input logic [31:0] sel, output logic [W-1:0] v);
    ctrl = sel;
    #1;
    v    = data_out;
    ctrl = '0;
  endtask

  // Issue a multiply and count cycles while busy, driving 'noise' onto ctrl meanwhile.
  task automatic run_mul(input logic [31:0] noise, output int n, output logic [7:0] mid_flags);
    cyc(B_MPY, '0);
    n         = 0;
    mid_flags = flags;
    ctrl      = noise;
    mbr_in    = 16'h5555;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 5) mid_flags = flags;
    end
    ctrl = '0;
  endtask

  task automatic test_reset;
    logic [W-1:0] v;
    cyc(B_MBR2ACC, 16'hABCD);
    cyc(B_MBR2BR, 16'h5555);
    #2;
    rst = 1'b0;
    #1;
    read_sel(B_ACC2MBR, v);
    if (v !== 16'h0000) begin errors++; $display("FAIL reset_acc: got %h expected 0000", v); end
    checks++;
    read_sel(B_MR2MBR, v);
    if (v !== 16'h0000) begin errors++; $display("FAIL reset_mr: got %h expected 0000", v); end
    checks++;
    if (flags !== 8'h02) begin errors++; $display("FAIL reset_flags: got %h expected 02", flags); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    rst = 1'b1;
    cyc(B_NOT, '0);
    read_sel(B_ACC2MBR, v);
    if (v !== 16'hFFFF) begin errors++; $display("FAIL reset_br_not: got %h expected ffff", v); end
    checks++;
  endtask

  task automatic test_load;
    logic [W-1:0] v;
    cyc(B_MBR2BR | B_CLR, 16'h1234);
    if (flags !== 8'h02) begin errors++; $display("FAIL clear_flags: got %h expected 02", flags); end
    checks++;
    cyc(B_ADD, '0);
    read_sel(B_ACC2MBR, v);
    if (v !== 16'h1234) begin errors++; $display("FAIL load_acc: got %h expected 1234", v); end
    checks++;
    if (flags !== 8'h00) begin errors++; $display("FAIL load_flags: got %h expected 00", flags); end
    checks++;
  endtask

  task automatic test_priority;
    logic [W-1:0] v;
    cyc(B_MBR2BR | B_MBR2ACC | B_ADD, 16'h0001);
    read_sel(B_ACC2MBR, v);
    if (v !== 16'h2468) begin errors++; $display("FAIL op_over_load_old_br: got %h expected 2468", v); end
    checks++;
    cyc(B_NOT, '0);
    read_sel(B_ALU2MBR, v);
    if (v !== 16'hFFFE) begin errors++; $display("FAIL br_parallel_load: got %h expected fffe", v); end
    checks++;
    cyc(B_MBR2ACC | B_CLR, 16'h0055);
    cyc(32'h0000_0021, 16'hAAAA);
    read_sel(B_ACC2MBR, v);
    if (v !== 16'h0055) begin errors++; $display("FAIL load_over_clear_hold: got %h expected 0055", v); end
    checks++;
    if (flags !== 8'h00) begin errors++; $display("FAIL hold_flags: got %h expected 00", flags); end
    checks++;
  endtask

  task automatic test_arith;
    logic [W-1:0] v;
    cyc(B_MBR2ACC, 16'h7FFF);
    cyc(B_MBR2BR, 16'h0001);
    cyc(B_ADD, '0);
    read_sel(B_ACC2MBR, v);
    if (v !== 16'h8000) begin errors++; $display("FAIL add_ovf_acc: got %h expected 8000", v); end
    checks++;
    if (flags !== 8'h09) begin errors++; $display("FAIL add_ovf_flags: got %h expected 09", flags); end
    checks++;
    cyc(B_MBR2BR, 16'h8000);
    cyc(B_SUB, '0);
    read_sel(B_ACC2MBR, v);
    if (v !== 16'h0000) begin errors++; $display("FAIL sub_zero_acc: got %h expected 0000", v); end
    checks++;
    if (flags !== 8'h06) begin errors++; $display("FAIL sub_zero_flags: got %h expected 06", flags); end
    checks++;
  endtask

  task automatic test_shifts;
    logic [W-1:0] v;
    cyc(B_MBR2ACC, 16'h8001);
    cyc(B_ASR, '0);
    read_sel(B_ACC2MBR, v);
    if (v !== 16'hC000 || flags[2:0] !== 3'b101) begin
      errors++; $display("FAIL asr: got %h/%b expected c000/101", v, flags[2:0]);
    end
    checks++;
    cyc(B_MBR2ACC, 16'h8001);
    cyc(B_LSR, '0);
    read_sel(B_ACC2MBR, v);
    if (v !== 16'h4000 || flags[2:0] !== 3'b100) begin
      errors++; $display("FAIL lsr: got %h/%b expected 4000/100", v, flags[2:0]);
    end
    checks++;
    cyc(B_MBR2ACC, 16'h8001);
    cyc(B_ASL, '0);
    read_sel(B_ACC2MBR, v);
    if (v !== 16'h0002 || flags[3:0] !== 4'b1100) begin
      errors++; $display("FAIL asl: got %h/%b expected 0002/1100", v, flags[3:0]);
    end
    checks++;
    cyc(B_MBR2ACC, 16'h8001);
    cyc(B_LSL | B_LSR, '0);
    read_sel(B_ACC2MBR, v);
    if (v !== 16'h0002 || flags[2:0] !== 3'b100) begin
      errors++; $display("FAIL lsl_wins: got %h/%b expected 0002/100", v, flags[2:0]);
    end
    checks++;
  endtask

  task automatic test_multiply;
    logic [W-1:0] v;
    logic [7:0]   mf;
    int           n;
    cyc(B_MBR2ACC, 16'h7FFD);
    cyc(B_MBR2BR, 16'h8000);
    cyc(B_SUB, '0);
    if (flags !== 8'h09) begin errors++; $display("FAIL premul_flags: got %h expected 09", flags); end
    checks++;
    cyc(B_MBR2BR, 16'h0007);
    run_mul(B_ADD | B_MBR2ACC, n, mf);
    if (n !== 17) begin errors++; $display("FAIL mul_latency: got %0d expected 17", n); end
    checks++;
    if (mf !== 8'h19) begin errors++; $display("FAIL mul_busy_flags: got %h expected 19", mf); end
    checks++;
    read_sel(B_ACC2MBR | B_MR2MBR, v);
    if (v !== 16'hFFEB) begin errors++; $display("FAIL mul_acc: got %h expected ffeb", v); end
    checks++;
    read_sel(B_MR2MBR, v);
    if (v !== 16'hFFFF) begin errors++; $display("FAIL mul_mr: got %h expected ffff", v); end
    checks++;
    if (flags !== 8'h01) begin errors++; $display("FAIL mul_flags: got %h expected 01", flags); end
    checks++;
  endtask

  task automatic test_mul_bounds;
    logic [W-1:0] v;
    logic [7:0]   mf;
    int           n;
    cyc(B_MBR2ACC, 16'hFFFD);
    cyc(B_MBR2BR, 16'h0000);
    run_mul('0, n, mf);
    read_sel(B_ACC2MBR, v);
    if (v !== 16'h0000 || flags !== 8'h02) begin
      errors++; $display("FAIL mul_by_zero: got %h/%h expected 0000/02", v, flags);
    end
    checks++;
    cyc(B_MBR2ACC, 16'h8000);
    cyc(B_MBR2BR, 16'h8000);
    run_mul('0, n, mf);
    read_sel(B_ACC2MBR, v);
    if (v !== 16'h0000) begin errors++; $display("FAIL mul_minneg_acc: got %h expected 0000", v); end
    checks++;
    read_sel(B_MR2MBR, v);
    if (v !== 16'h4000 || flags !== 8'h00) begin
      errors++; $display("FAIL mul_minneg_mr: got %h/%h expected 4000/00", v, flags);
    end
    checks++;
  endtask

  task automatic test_reset_mid_mul;
    logic [W-1:0] v;
    logic [7:0]   mf;
    int           n;
    cyc(B_MBR2ACC, 16'h0100);
    cyc(B_MBR2BR, 16'h0100);
    cyc(B_MPY, '0);
    repeat (8) @(posedge clk);
    #2;
    rst  = 1'b0;
    ctrl = B_MR2MBR;
    #1;
    if (busy !== 1'b0 || data_out !== 16'h0000) begin
      errors++; $display("FAIL midmul_reset: got busy=%b mr=%h expected 0/0000", busy, data_out);
    end
    checks++;
    ctrl = '0;
    #1;
    rst = 1'b1;
    cyc(B_MBR2ACC, 16'h0002);
    cyc(B_MBR2BR, 16'h0003);
    run_mul('0, n, mf);
    if (n !== 17) begin errors++; $display("FAIL post_reset_latency: got %0d expected 17", n); end
    checks++;
    read_sel(B_ACC2MBR, v);
    if (v !== 16'h0006) begin errors++; $display("FAIL post_reset_acc: got %h expected 0006", v); end
    checks++;
    read_sel(B_MR2MBR, v);
    if (v !== 16'h0000 || flags !== 8'h00) begin
      errors++; $display("FAIL post_reset_mr: got %h/%h expected 0000/00", v, flags);
    end
    checks++;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ctrl   = '0;
    mbr_in = '0;
    rst    = 1'b0;
    #12;
    rst = 1'b1;
    test_reset();
    test_load();
    test_priority();
    test_arith();
    test_shifts();
    test_multiply();
    test_mul_bounds();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
